// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RWAIT,
    ACK
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Master request/ack and RAM control signals of the arbiter; the shared data bus stays a plain inout.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              ram_wr_en_o;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              busy_o;

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m1_req_i, m1_addr_i,
    input  m0_ack_o, m0_rdata_o, m1_ack_o, m1_rdata_o,
    input  ram_wr_en_o, ram_rd_en_o, ram_addr_o, busy_o
  );

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m1_req_i, m1_addr_i,
    output m0_ack_o, m0_rdata_o, m1_ack_o, m1_rdata_o,
    output ram_wr_en_o, ram_rd_en_o, ram_addr_o, busy_o
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way grant picker, combinational; round-robin on the last grant, or fixed m0 priority
// when RAM_ARB_FIXED_PRIO_EN is defined. The pointer only moves when take is high.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk_i, rst_i, take, req1};
  assign gnt    = req0 ? M0 : M1;
`else
  logic last_q;

  // Reset to "m1 granted last" so the first contested request goes to m0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    last_q <= M1;
    else if (take) last_q <= gnt;
  end

  always_comb begin
    gnt = M0;
    if (req0 && req1) gnt = ~last_q;
    else if (req1)    gnt = M1;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates m0 (read/write) and m1 (read-only) onto one RAM; writes ack 2 cycles after the
// sampled request, reads 2+RD_LAT. Requests seen while busy wait until IDLE. Macro: RAM_ARB_FIXED_PRIO_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ram_arbiter_if.slave      bus,
  inout  wire  [DATA_W-1:0] ram_data_io
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              gnt, gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [1:0]        lat_q;
  logic              any_req, take, lat_last;

  assign any_req  = bus.m0_req_i | bus.m1_req_i;
  assign take     = (state_q == IDLE) && any_req;
  assign lat_last = (lat_q == LAT_LAST);

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req0  (bus.m0_req_i),
    .req1  (bus.m1_req_i),
    .take  (take),
    .gnt   (gnt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_q    <= M0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (take) begin
        gnt_q   <= gnt;
        addr_q  <= (gnt == M1) ? bus.m1_addr_i : bus.m0_addr_i;
        wdata_q <= bus.m0_wdata_i;
      end
      if (state_q == RD)         lat_q <= '0;
      else if (state_q == RWAIT) lat_q <= lat_q + 2'd1;
      // Read data is captured on the edge that closes the last RWAIT cycle.
      if (state_q == RWAIT && lat_last) begin
        if (gnt_q == M0) rdata0_q <= ram_data_io;
        else             rdata1_q <= ram_data_io;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.ram_wr_en_o = 1'b0;
    bus.ram_rd_en_o = 1'b0;
    bus.ram_addr_o  = '0;
    bus.m0_ack_o    = 1'b0;
    bus.m1_ack_o    = 1'b0;
    bus.busy_o      = (state_q != IDLE);
    case (state_q)
      IDLE: if (any_req) state_d = (gnt == M0 && bus.m0_we_i) ? WR : RD;
      WR: begin
        bus.ram_wr_en_o = 1'b1;
        bus.ram_addr_o  = addr_q;
        state_d         = ACK;
      end
      RD: begin
        bus.ram_rd_en_o = 1'b1;
        bus.ram_addr_o  = addr_q;
        state_d         = RWAIT;
      end
      RWAIT: if (lat_last) state_d = ACK;
      ACK: begin
        bus.m0_ack_o = (gnt_q == M0);
        bus.m1_ack_o = (gnt_q == M1);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m0_rdata_o = rdata0_q;
  assign bus.m1_rdata_o = rdata1_q;
  assign ram_data_io    = (state_q == WR) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Two arbiters (RD_LAT 1 and 3) on pulled-up buses with a small RAM model each.
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 4;

  typedef struct {
    int inst;
    int m;
    int rd;
    int data;
    int addr;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t ack_q[$];
  exp_t wr_q[$];
  exp_t rd_q[$];

  logic [1:0]         m0_req = '0, m0_we = '0, m1_req = '0;
  logic [1:0][AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [1:0][DW-1:0] m0_wdata = '0;
  logic [1:0]         m0_ack, m1_ack, wr_en, rd_en, busy, drv;
  logic [1:0][AW-1:0] raddr;
  logic [1:0][DW-1:0] m0_rd, m1_rd, bus_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = 1 + 2 * g;
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    tri1 [DW-1:0]  data;
    logic [DW-1:0] mem [256];
    logic [255:0]  written = '0;
    logic [2:0]    rd_pipe;
    logic [AW-1:0] a_pipe [3];
    logic [AW-1:0] ra;
    logic [DW-1:0] rv;

    assign bus.m0_req_i   = m0_req[g];
    assign bus.m0_we_i    = m0_we[g];
    assign bus.m0_addr_i  = m0_addr[g];
    assign bus.m0_wdata_i = m0_wdata[g];
    assign bus.m1_req_i   = m1_req[g];
    assign bus.m1_addr_i  = m1_addr[g];
    assign m0_ack[g] = bus.m0_ack_o;
    assign m1_ack[g] = bus.m1_ack_o;
    assign m0_rd[g]  = bus.m0_rdata_o;
    assign m1_rd[g]  = bus.m1_rdata_o;
    assign wr_en[g]  = bus.ram_wr_en_o;
    assign rd_en[g]  = bus.ram_rd_en_o;
    assign raddr[g]  = bus.ram_addr_o;
    assign busy[g]   = bus.busy_o;
    assign bus_v[g]  = data;

    // RAM returns data only in the cycle RD_LAT after rd_en; unwritten cells read addr ^ 5.
    assign drv[g] = rd_pipe[LAT-1];
    assign ra     = a_pipe[LAT-1];
    assign rv     = written[ra] ? mem[ra] : (ra[DW-1:0] ^ 4'h5);
    assign data   = drv[g] ? rv : 'z;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_pipe <= '0;
      end else begin
        rd_pipe   <= {rd_pipe[1:0], bus.ram_rd_en_o};
        a_pipe[0] <= bus.ram_addr_o;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        if (bus.ram_wr_en_o) begin
          mem[bus.ram_addr_o]     <= data;
          written[bus.ram_addr_o] <= 1'b1;
        end
      end
    end

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .bus         (bus),
      .ram_data_io (data)
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int g);
    checks++;
    failures++;
    $display("FAIL %s inst=%0d: got an event, expected none (cycle %0d)", name, g, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 2; g++) begin
        automatic exp_t e;
        chk("rw_exclusive", int'(wr_en[g] & rd_en[g]), 0);
        if (!busy[g]) chk("idle_addr", int'(raddr[g]), 0);
        if (!wr_en[g] && !drv[g]) chk("bus_highz", int'(bus_v[g]), 15);
        if (wr_en[g]) begin
          if (wr_q.size() == 0) unexpected("wr_en", g);
          else begin
            e = wr_q.pop_front();
            chk("wr_inst", g, e.inst);
            chk("wr_addr", int'(raddr[g]), e.addr);
            chk("wr_data", int'(bus_v[g]), e.data);
            chk("wr_cycle", cyc, e.cyc);
          end
        end
        if (rd_en[g]) begin
          if (rd_q.size() == 0) unexpected("rd_en", g);
          else begin
            e = rd_q.pop_front();
            chk("rd_inst", g, e.inst);
            chk("rd_addr", int'(raddr[g]), e.addr);
            chk("rd_cycle", cyc, e.cyc);
          end
        end
        if (m0_ack[g] || m1_ack[g]) begin
          chk("ack_onehot", int'(m0_ack[g] & m1_ack[g]), 0);
          if (ack_q.size() == 0) unexpected("ack", g);
          else begin
            e = ack_q.pop_front();
            chk("ack_inst", g, e.inst);
            chk("ack_master", int'(m1_ack[g]), e.m);
            chk("ack_cycle", cyc, e.cyc);
            if (e.rd != 0) chk("rdata", (e.m != 0) ? int'(m1_rd[g]) : int'(m0_rd[g]), e.data);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int g, input int m);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (m != 0) ? m1_ack[g] : m0_ack[g];
    end
    chk("ack_seen", int'(seen), 1);
  endtask

  task automatic m0_write(input int g, input int a, input int d);
    @(negedge clk);
    m0_req[g] = 1'b1; m0_we[g] = 1'b1; m0_addr[g] = AW'(a); m0_wdata[g] = DW'(d);
    wr_q.push_back('{g, 0, 0, d, a, cyc + 1});
    ack_q.push_back('{g, 0, 0, 0, a, cyc + 2});
    wait_ack(g, 0);
    m0_req[g] = 1'b0; m0_we[g] = 1'b0;
  endtask

  task automatic m_read(input int g, input int m, input int a, input int d);
    @(negedge clk);
    if (m == 0) begin
      m0_req[g] = 1'b1; m0_we[g] = 1'b0; m0_addr[g] = AW'(a);
    end else begin
      m1_req[g] = 1'b1; m1_addr[g] = AW'(a);
    end
    rd_q.push_back('{g, m, 1, 0, a, cyc + 1});
    ack_q.push_back('{g, m, 1, d, a, cyc + 3 + 2 * g});
    wait_ack(g, m);
    m0_req[g] = 1'b0; m1_req[g] = 1'b0;
  endtask

  task automatic reset_checks(input int g);
    chk("rst_busy", int'(busy[g]), 0);
    chk("rst_m0_ack", int'(m0_ack[g]), 0);
    chk("rst_m1_ack", int'(m1_ack[g]), 0);
    chk("rst_wr_en", int'(wr_en[g]), 0);
    chk("rst_rd_en", int'(rd_en[g]), 0);
    chk("rst_addr", int'(raddr[g]), 0);
    chk("rst_m0_rdata", int'(m0_rd[g]), 0);
    chk("rst_m1_rdata", int'(m1_rd[g]), 0);
    chk("rst_bus_highz", int'(bus_v[g]), 15);
  endtask

  initial begin
    int n;
    int acks;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) reset_checks(g);
    rst_n = 1'b1;

    m0_write(0, 'h2A, 'h9);
    m_read(0, 1, 'h2A, 'h9);
    m0_write(0, 'h10, 'h3);
    chk("m1_rdata_hold", int'(m1_rd[0]), 'h9);
    m_read(0, 0, 'h10, 'h3);
    chk("m1_rdata_hold2", int'(m1_rd[0]), 'h9);
    m_read(0, 1, 'h2A, 'h9);

    // Both masters held: m1 was granted last, so m0 goes first.
    @(negedge clk);
    n = cyc;
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 8'h20; m0_wdata[0] = 4'h5;
    m1_req[0] = 1'b1; m1_addr[0] = 8'h10;
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      wr_q.push_back('{0, 0, 0, 'h5, 'h20, n + 1 + 3 * k});
      ack_q.push_back('{0, 0, 0, 0, 'h20, n + 2 + 3 * k});
    end
`else
    wr_q.push_back('{0, 0, 0, 'h5, 'h20, n + 1});
    ack_q.push_back('{0, 0, 0, 0, 'h20, n + 2});
    rd_q.push_back('{0, 1, 1, 0, 'h10, n + 4});
    ack_q.push_back('{0, 1, 1, 'h3, 'h10, n + 6});
    wr_q.push_back('{0, 0, 0, 'h5, 'h20, n + 8});
    ack_q.push_back('{0, 0, 0, 0, 'h20, n + 9});
    rd_q.push_back('{0, 1, 1, 0, 'h10, n + 11});
    ack_q.push_back('{0, 1, 1, 'h3, 'h10, n + 13});
`endif
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (m0_ack[0] || m1_ack[0]) acks++;
    end
    chk("contend_ack_count", acks, 4);
    m0_req[0] = 1'b0; m0_we[0] = 1'b0; m1_req[0] = 1'b0;

    m_read(1, 0, 'hFF, 'hA);

    // Reset in the second RWAIT cycle of an m1 read aborts it silently.
    @(negedge clk);
    m1_req[1] = 1'b1; m1_addr[1] = 8'h33;
    rd_q.push_back('{1, 1, 1, 0, 'h33, cyc + 1});
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 reset_checks(1);
    m1_req[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    m_read(1, 1, 'h33, 'h6);

    repeat (5) @(negedge clk);
    chk("ack_q_empty", ack_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1);
  end

endmodule
